soc_system_pio_in_edge: RTL and testbench

//  Avalon-MM slave input PIO: the read-side counterpart of the LED output PIO. Samples WIDTH

---
 rtl/soc_system_pio_in_edge.sv | 139 +++++++++++++
 tb/tb_soc_system_pio_in_edge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_in_edge.sv
// -----------------------------------------------------------------------------
// soc_system_pio_in_edge
//
// Avalon-MM slave input PIO. Samples WIDTH asynchronous board inputs,
// synchronises them through two flops, debounces each bit with its own
// stability counter, latches qualifying edges of the debounced value and
// raises a level interrupt while any unmasked captured edge is pending.
//
// Bus handshake: there is no valid/ready pair on this slave. A write is
// accepted on every clk edge where chipselect=1 and write_n=0. Reads are
// zero-latency: readdata is a combinational mux of the addressed register,
// independent of chipselect, and reading has no side effects.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-high reset
//   address     word address: 0 data, 1 reserved, 2 irq mask, 3 edge capture
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (low WIDTH bits used)
//   readdata    read data, upper 32-WIDTH bits always 0
//   in_port     asynchronous external inputs
//   irq         level interrupt = |(edge capture & irq mask)
// -----------------------------------------------------------------------------
module soc_system_pio_in_edge #(
    parameter int                 WIDTH           = 4,
    parameter int                 DEBOUNCE_CYCLES = 16,
    parameter int                 EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0]   RESET_VALUE     = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] edge_set;
    logic             wr_en;

    // Upper writedata bits have no destination when WIDTH < 32.
    if (WIDTH < 32) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^writedata[31:WIDTH];
    end

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        sync1_d    = in_port;
        sync2_d    = sync1_q;
        db_d       = db_q;
        irq_mask_d = irq_mask_q;
        edge_cap_d = edge_cap_q;
        edge_set   = '0;

        // Per-bit debounce: the debounced value follows the synchronised
        // input only after DEBOUNCE_CYCLES consecutive disagreeing samples;
        // any sample that agrees again restarts the count.
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end

        if (EDGE_TYPE == 0) begin
            edge_set = db_d & ~db_q;
        end else if (EDGE_TYPE == 1) begin
            edge_set = ~db_d & db_q;
        end else begin
            edge_set = db_d ^ db_q;
        end

        if (wr_en && (address == 2'd2)) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == 2'd3)) begin
            edge_cap_d = edge_cap_d & ~writedata[WIDTH-1:0];
        end
        // A new edge in the same cycle as its clear must not be lost.
        edge_cap_d = edge_cap_d | edge_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= RESET_VALUE;
            sync2_q    <= RESET_VALUE;
            db_q       <= RESET_VALUE;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = 32'(db_q);
            2'd1:    readdata = '0;
            2'd2:    readdata = 32'(irq_mask_q);
            default: readdata = 32'(edge_cap_q);
        endcase
    end

    assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// -----------------------------------------------------------------------------
// tb_soc_system_pio_in_edge
//
// Bench for soc_system_pio_in_edge with WIDTH=4, DEBOUNCE_CYCLES=4,
// EDGE_TYPE=0 (rising), RESET_VALUE=0. Directed scenarios followed by a
// randomised phase. The reference model keeps a sliding window of the last
// DEBOUNCE_CYCLES synchronised samples: a debounced bit flips when every
// sample in that window disagrees with it.
// -----------------------------------------------------------------------------
module tb_soc_system_pio_in_edge;

    localparam int W = 4;
    localparam int D = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    soc_system_pio_in_edge #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .EDGE_TYPE      (0),
        .RESET_VALUE    (4'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] m_sync1, m_sync2, m_db, m_mask, m_cap;
    logic [W-1:0] s2_hist[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync1 = '0;
        m_sync2 = '0;
        m_db    = '0;
        m_mask  = '0;
        m_cap   = '0;
        s2_hist.delete();
    endtask

    // One rising clock edge, using the inputs present just before the edge.
    task automatic model_edge();
        logic [W-1:0] new_db;
        logic         all_diff;
        s2_hist.push_back(m_sync2);
        if (s2_hist.size() > D) void'(s2_hist.pop_front());
        new_db = m_db;
        if (s2_hist.size() == D) begin
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (s2_hist[j][i] == m_db[i]) all_diff = 1'b0;
                end
                if (all_diff) new_db[i] = ~m_db[i];
            end
        end
        if (chipselect && !write_n) begin
            if (address == 2'd2) m_mask = writedata[W-1:0];
            if (address == 2'd3) m_cap  = m_cap & ~writedata[W-1:0];
        end
        m_cap   = m_cap | (new_db & ~m_db);
        m_db    = new_db;
        m_sync2 = m_sync1;
        m_sync1 = in_port;
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_db};
            2'd1:    return 32'd0;
            2'd2:    return {28'd0, m_mask};
            default: return {28'd0, m_cap};
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Advance one clock, then compare irq and every register with the model.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        check_eq("irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            check_eq($sformatf("rd_addr%0d", a), readdata, exp_rd(2'(a)));
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick();
    endtask

    task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check_eq(tag, readdata, exp);
    endtask

    // Asynchronous reset, checked while held, released on a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        read_chk("rst_addr0", 2'd0, 32'd0);
        read_chk("rst_addr2", 2'd2, 32'd0);
        read_chk("rst_addr3", 2'd3, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hold;
        reset      = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_port    = 4'hF;
        model_reset();
        #2;

        // 1: reset with all inputs high, debounced value appears on 6th edge
        do_reset();
        ticks(5);
        read_chk("t1_db_edge5", 2'd0, 32'h0);
        tick();
        read_chk("t1_db_edge6", 2'd0, 32'hF);
        read_chk("t1_cap", 2'd3, 32'hF);
        check_eq("t1_irq", {31'd0, irq}, 32'd0);

        // 2: bring inputs low, clear captures, then a 3-cycle glitch on bit0
        in_port = 4'h0;
        ticks(8);
        bus_write(2'd3, 32'hF);
        in_port = 4'h1;
        ticks(3);
        in_port = 4'h0;
        ticks(8);
        read_chk("t2_db", 2'd0, 32'h0);
        read_chk("t2_cap", 2'd3, 32'h0);

        // 3: mask bit0, stable rising bit0 raises irq on the 6th edge
        bus_write(2'd2, 32'h1);
        in_port = 4'h1;
        ticks(5);
        check_eq("t3_irq_edge5", {31'd0, irq}, 32'd0);
        tick();
        check_eq("t3_irq_edge6", {31'd0, irq}, 32'd1);
        bus_write(2'd3, 32'h1);
        check_eq("t3_irq_cleared", {31'd0, irq}, 32'd0);
        in_port = 4'h0;
        ticks(8);
        read_chk("t3_no_fall_cap", 2'd3, 32'h0);

        // 4: clear of bit1 lands on the edge where bit1 debounces high
        bus_write(2'd2, 32'h3);
        in_port = 4'h2;
        ticks(5);
        bus_write(2'd3, 32'h2);
        read_chk("t4_cap_set_wins", 2'd3, 32'h2);
        check_eq("t4_irq", {31'd0, irq}, 32'd1);

        // 5: pending edge on bit2 with mask 0, then unmask; dead addresses
        bus_write(2'd2, 32'h0);
        in_port = 4'h6;
        ticks(7);
        check_eq("t5_irq_masked", {31'd0, irq}, 32'd0);
        bus_write(2'd2, 32'h4);
        check_eq("t5_irq_unmasked", {31'd0, irq}, 32'd1);
        read_chk("t5_addr1", 2'd1, 32'h0);
        read_chk("t5_addr2", 2'd2, 32'h4);
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        read_chk("t5_addr0_kept", 2'd0, 32'h6);
        read_chk("t5_addr2_kept", 2'd2, 32'h4);
        read_chk("t5_addr3_kept", 2'd3, 32'h6);

        // 6: reset while bit3 is mid-debounce (count 2)
        in_port = 4'hE;
        ticks(4);
        do_reset();
        ticks(8);
        read_chk("t6_db_fresh", 2'd0, 32'hE);
        read_chk("t6_cap_fresh", 2'd3, 32'hE);

        // random phase
        hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                in_port = 4'($urandom_range(0, 15));
                hold    = $urandom_range(1, 9);
            end
            hold--;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                address    = 2'($urandom_range(0, 3));
                chipselect = 1'($urandom_range(0, 1));
                write_n    = 1'($urandom_range(0, 1));
                writedata  = $urandom();
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
